// File: rtl/fifo_wr_rr_arb.sv
// fifo_wr_rr_arb: round-robin arbiter sharing one FIFO write port among N requesters.
// Optional locked bursts of up to BURST_LEN beats via macro FIFO_WR_RR_ARB_BURST_EN.
`default_nettype none

module fifo_wr_rr_arb #(
   parameter  int N         = 4,
   parameter  int DAT_WID   = 8,
   parameter  int BURST_LEN = 4,
   localparam int IDX_WID   = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*DAT_WID-1:0] din,
   input  logic                 fifo_full,
   output logic [N-1:0]         gnt,
   output logic [IDX_WID-1:0]   gnt_idx,
   output logic                 wen,
   output logic [DAT_WID-1:0]   dout
);

   if (N < 2 || BURST_LEN < 1) begin : g_cfg_check
      $error("fifo_wr_rr_arb: requires N >= 2 and BURST_LEN >= 1");
   end

   logic [IDX_WID-1:0] prio;
   logic [N-1:0]       elig;
   logic               found;
   logic [IDX_WID-1:0] win;
   int                 pos;

   function automatic logic [IDX_WID-1:0] next_idx(input logic [IDX_WID-1:0] i);
      return (i == IDX_WID'(N - 1)) ? '0 : i + IDX_WID'(1);
   endfunction

`ifdef FIFO_WR_RR_ARB_BURST_EN
   localparam int BCNT_WID = $clog2(BURST_LEN + 1);

   logic                lock;
   logic [IDX_WID-1:0]  lock_idx;
   logic [BCNT_WID-1:0] bcnt;
`endif

   always_comb begin
      elig = req;
`ifdef FIFO_WR_RR_ARB_BURST_EN
      // While locked only the burst owner may win.
      if (lock)
         elig = req & (N'(1) << lock_idx);
`endif
      found = 1'b0;
      win   = '0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(prio) + k) % N;
         if (!found && elig[pos]) begin
            found = 1'b1;
            win   = IDX_WID'(pos);
         end
      end

      gnt     = '0;
      gnt_idx = '0;
      wen     = 1'b0;
      dout    = '0;
      // Outputs are forced quiet during reset and whenever the FIFO is full.
      if (rst_n && !fifo_full && found) begin
         gnt[win] = 1'b1;
         gnt_idx  = win;
         wen      = 1'b1;
         dout     = din[win*DAT_WID +: DAT_WID];
      end
   end

`ifdef FIFO_WR_RR_ARB_BURST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio     <= '0;
         lock     <= 1'b0;
         lock_idx <= '0;
         bcnt     <= '0;
      end else if (!fifo_full) begin
         if (!lock) begin
            if (wen) begin
               if (BURST_LEN == 1) begin
                  prio <= next_idx(gnt_idx);
               end else begin
                  lock     <= 1'b1;
                  lock_idx <= gnt_idx;
                  bcnt     <= BCNT_WID'(1);
               end
            end
         end else if (wen) begin
            if (bcnt + BCNT_WID'(1) == BCNT_WID'(BURST_LEN)) begin
               lock <= 1'b0;
               bcnt <= '0;
               prio <= next_idx(lock_idx);
            end else begin
               bcnt <= bcnt + BCNT_WID'(1);
            end
         end else if (!req[lock_idx]) begin
            // Owner went away: give up the rest of the burst.
            lock <= 1'b0;
            bcnt <= '0;
            prio <= next_idx(lock_idx);
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prio <= '0;
      else if (wen)
         prio <= next_idx(gnt_idx);
   end
`endif

endmodule

`default_nettype wire
